// File: rtl/irq_vector_ctrl.sv
// N-channel vectored interrupt controller: synchronised edge capture, pending/mask, priority select, nested service stack.
// Optional debounce on the synchronised inputs is enabled with `define IRQ_DEBOUNCE_EN.
module irq_vector_ctrl #(
   parameter int               N_IRQ      = 4,
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0000,
   parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010,
   parameter int               DB_CYCLES  = 16,
   localparam int              ID_W       = $clog2(N_IRQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IRQ-1:0]  irq_in,
   input  logic              ie,
   input  logic              ack,
   input  logic              eret,
   input  logic              mask_we,
   input  logic [N_IRQ-1:0]  mask_din,
   output logic              int_req,
   output logic [ID_W-1:0]   int_id,
   output logic [WIDTH-1:0]  int_vec,
   output logic [N_IRQ-1:0]  irw,
   output logic [N_IRQ-1:0]  in_service,
   output logic [ID_W:0]     depth
);

   localparam int STK_N = 2 ** ID_W;

   if (N_IRQ < 2 || N_IRQ > 16) begin : g_bad_n
      $error("irq_vector_ctrl: N_IRQ must be in 2..16");
   end
   if (DB_CYCLES < 1) begin : g_bad_db
      $error("irq_vector_ctrl: DB_CYCLES must be at least 1");
   end

   logic [N_IRQ-1:0] sync1, sync2, level, prev, rise_q;
   logic [N_IRQ-1:0] pending, pending_n, mask, in_service_n;
   logic [ID_W-1:0]  stk [STK_N];
   logic [ID_W-1:0]  top_id, id_sel, push_idx;
   logic [ID_W:0]    cur_level, depth_pop, depth_n;
   logic [N_IRQ-1:0] eligible;
   logic             ack_hon, pop;

`ifdef IRQ_DEBOUNCE_EN
   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DB_CYCLES - 1);

   logic [N_IRQ-1:0] db_lvl;
   logic [DB_W-1:0]  db_cnt [N_IRQ];

   // Down-counter reloads whenever sync2 agrees with the debounced level;
   // terminal count means DB_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_lvl <= '0;
         for (int i = 0; i < N_IRQ; i++) db_cnt[i] <= DB_RELOAD;
      end else begin
         for (int i = 0; i < N_IRQ; i++) begin
            if (sync2[i] != db_lvl[i]) begin
               if (db_cnt[i] == '0) begin
                  db_lvl[i] <= sync2[i];
                  db_cnt[i] <= DB_RELOAD;
               end else begin
                  db_cnt[i] <= db_cnt[i] - 1'b1;
               end
            end else begin
               db_cnt[i] <= DB_RELOAD;
            end
         end
      end
   end

   assign level = db_lvl;
`else
   assign level = sync2;
`endif

   assign top_id    = stk[ID_W'(depth - 1'b1)];
   assign cur_level = (depth == '0) ? '0 : ({1'b0, top_id} + 1'b1);

   always_comb begin
      eligible = '0;
      id_sel   = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         eligible[i] = pending[i] & mask[i] & ((ID_W+1)'(i + 1) > cur_level);
         if (eligible[i]) id_sel = ID_W'(i);
      end
   end

   assign int_req = ie & (|eligible);
   assign int_id  = id_sel;
   assign int_vec = VEC_BASE + (WIDTH'(id_sel) * VEC_STRIDE);

   assign ack_hon = ack & int_req;
   assign pop     = eret & (depth != '0);

   // Pop is applied before the push so ack+eret replaces the top entry.
   always_comb begin
      depth_pop    = pop ? (depth - 1'b1) : depth;
      depth_n      = ack_hon ? (depth_pop + 1'b1) : depth_pop;
      push_idx     = ID_W'(depth_pop);
      in_service_n = in_service;
      if (pop)     in_service_n[top_id] = 1'b0;
      if (ack_hon) in_service_n[id_sel] = 1'b1;
      pending_n = pending;
      if (ack_hon) pending_n[id_sel] = 1'b0;
      pending_n = pending_n | rise_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= '0;
         sync2      <= '0;
         prev       <= '0;
         rise_q     <= '0;
         pending    <= '0;
         mask       <= '1;
         in_service <= '0;
         depth      <= '0;
         for (int i = 0; i < STK_N; i++) stk[i] <= '0;
      end else begin
         sync1      <= irq_in;
         sync2      <= sync1;
         prev       <= level;
         rise_q     <= level & ~prev;
         pending    <= pending_n;
         if (mask_we) mask <= mask_din;
         in_service <= in_service_n;
         depth      <= depth_n;
         if (ack_hon) stk[push_idx] <= id_sel;
      end
   end

   assign irw = pending;

endmodule
